// File: rtl/unified_memory_pipe.sv
`default_nettype none
// ============================================================================
// Module   : unified_memory_pipe
// Purpose  : Word-organised memory shared by the instruction fetch port and the
//            data load/store port. After reset it writes INIT_VAL into every
//            word before it starts accepting requests. Stores support byte-lane
//            enables. Reads have a fixed latency of RD_LAT cycles (1 or 2).
//            Accesses that are misaligned or outside the array complete as
//            zero-data responses and raise addr_err instead of touching memory.
// Ports    : clk, reset (async, active-high)
//            ready                      - high once the fill has completed
//            instr_req/addr             - fetch request
//            instr_valid/data           - fetch response
//            data_req/we/be/addr/wdata  - load/store request
//            data_rvalid/rdata          - load response (loads only)
//            addr_err                   - bad-access pulse in the response slot
// Revision : 1.0  initial release
// ============================================================================
module unified_memory_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 512,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                instr_req,
    input  logic [ADDR_W-1:0]   instr_addr,
    output logic                instr_valid,
    output logic [DATA_W-1:0]   instr_data,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [DATA_W/8-1:0] data_be,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                addr_err
);

    localparam int c_nb   = DATA_W / 8;
    localparam int c_offs = $clog2(c_nb);
    localparam int c_idx  = $clog2(DEPTH);
    // Address bits that may legally be set: exactly the word-index field.
    // Anything else (byte offset or bits above the array) marks a bad access.
    localparam logic [ADDR_W-1:0] c_idx_mask = ADDR_W'(DEPTH - 1) << c_offs;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_idx-1:0]   r_fill_cnt;
    logic               r_ready;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [c_idx-1:0]   w_i_idx;
    logic [c_idx-1:0]   w_d_idx;
    logic               w_i_bad;
    logic               w_d_bad;
    logic               w_i_acc;
    logic               w_d_acc;
    logic               w_d_ld;
    logic               w_d_st;
    logic               w_fill;

    // First pipeline stage, loaded at the accept edge
    logic               r_i_v1;
    logic               r_i_e1;
    logic [DATA_W-1:0]  r_i_d1;
    logic               r_d_v1;
    logic               r_d_e1;
    logic [DATA_W-1:0]  r_d_d1;

    assign w_i_idx = instr_addr[c_offs +: c_idx];
    assign w_d_idx = data_addr[c_offs +: c_idx];
    assign w_i_bad = |(instr_addr & ~c_idx_mask);
    assign w_d_bad = |(data_addr & ~c_idx_mask);
    assign w_i_acc = instr_req & r_ready;
    assign w_d_acc = data_req & r_ready;
    assign w_d_ld  = w_d_acc & ~data_we;
    assign w_d_st  = w_d_acc & data_we & ~w_d_bad;
    assign w_fill  = (r_state == ST_FILL);
    assign ready   = r_ready;

    // Fill sequencer: one word per cycle, then RUN until the next reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
            r_ready    <= 1'b0;
        end else if (r_state == ST_FILL) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
            if (r_fill_cnt == c_idx'(DEPTH - 1)) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    // Array writes. Reads in the stage below see the pre-store contents on
    // the same edge, which yields read-before-write for colliding accesses.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            mem[r_fill_cnt] <= INIT_VAL;
        end else if (w_d_st) begin
            for (int i = 0; i < c_nb; i++) begin
                if (data_be[i]) begin
                    mem[w_d_idx][8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_v1 <= 1'b0;
            r_i_e1 <= 1'b0;
            r_i_d1 <= '0;
            r_d_v1 <= 1'b0;
            r_d_e1 <= 1'b0;
            r_d_d1 <= '0;
        end else begin
            r_i_v1 <= w_i_acc;
            r_i_e1 <= w_i_acc & w_i_bad;
            if (w_i_acc) begin
                r_i_d1 <= w_i_bad ? '0 : mem[w_i_idx];
            end
            // Stores report errors but never produce a load response
            r_d_v1 <= w_d_ld;
            r_d_e1 <= w_d_acc & w_d_bad;
            if (w_d_ld) begin
                r_d_d1 <= w_d_bad ? '0 : mem[w_d_idx];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic               r_i_v2;
        logic               r_i_e2;
        logic [DATA_W-1:0]  r_i_d2;
        logic               r_d_v2;
        logic               r_d_e2;
        logic [DATA_W-1:0]  r_d_d2;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_i_v2 <= 1'b0;
                r_i_e2 <= 1'b0;
                r_i_d2 <= '0;
                r_d_v2 <= 1'b0;
                r_d_e2 <= 1'b0;
                r_d_d2 <= '0;
            end else begin
                r_i_v2 <= r_i_v1;
                r_i_e2 <= r_i_e1;
                r_d_v2 <= r_d_v1;
                r_d_e2 <= r_d_e1;
                // Data registers only move on a response so outputs hold
                if (r_i_v1) begin
                    r_i_d2 <= r_i_d1;
                end
                if (r_d_v1) begin
                    r_d_d2 <= r_d_d1;
                end
            end
        end

        assign instr_valid = r_i_v2;
        assign instr_data  = r_i_d2;
        assign data_rvalid = r_d_v2;
        assign data_rdata  = r_d_d2;
        assign addr_err    = r_i_e2 | r_d_e2;
    end else begin : g_lat1
        assign instr_valid = r_i_v1;
        assign instr_data  = r_i_d1;
        assign data_rvalid = r_d_v1;
        assign data_rdata  = r_d_d1;
        assign addr_err    = r_i_e1 | r_d_e1;
    end

endmodule
`default_nettype wire

// File: doc/unified_memory_pipe.md
Name: unified_memory_pipe

Overview:
Parametrised successor to the single-cycle instruction/data memory. It has a dual-port word array with an instruction fetch port and a data load/store port. It adds byte-lane write enables, a configurable read latency (1 or 2), address checking, and a post-reset fill sequencer that initialises every word before requests are accepted. The block sits between the fetch/LSU stages and backs both with one array.

Parameters:
DATA_W, 32, word width in bits; a multiple of 8, with DATA_W/8 a power of 2.
ADDR_W, 32, byte-address width on both ports.
DEPTH, 512, number of words; a power of 2.
RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
INIT_VAL, 0, value written to every word by the fill sequencer.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
ready  output  1  high when the block accepts requests (RUN state).
instr_req  input  1  fetch request this cycle.
instr_addr  input  ADDR_W  fetch byte address.
instr_valid  output  1  one-cycle pulse when fetch data is valid.
instr_data  output  DATA_W  fetched word; holds its value between pulses.
data_req  input  1  load/store request this cycle.
data_we  input  1  1 = store, 0 = load.
data_be  input  DATA_W/8  store byte-lane enables; bit i covers bits 8i+7:8i.
data_addr  input  ADDR_W  load/store byte address.
data_wdata  input  DATA_W  store data.
data_rvalid  output  1  one-cycle pulse when load data is valid; never pulses for stores.
data_rdata  output  DATA_W  loaded word; holds its value between pulses.
addr_err  output  1  one-cycle pulse flagging a bad access, aligned to that access's response slot.

Behaviour:
- OFFS = log2(DATA_W/8); IDX = log2(DEPTH).
- Word index = addr[OFFS+IDX-1:OFFS].
- An address is bad if addr[OFFS-1:0] != 0 or any bit above OFFS+IDX-1 is set.
- Reset asserted (asynchronous):
  - ready=0; instr_valid=0, data_rvalid=0, addr_err=0; instr_data=0, data_rdata=0.
  - Read pipeline cleared; in-flight responses are dropped.
  - FSM goes to FILL with fill counter=0.
- FILL: writes INIT_VAL to mem[counter] each cycle and increments the counter. After writing word DEPTH-1 it moves to RUN.
  - FILL lasts exactly DEPTH cycles after reset deasserts.
  - ready stays 0 throughout; requests are ignored and produce no response or error.
  - Reset asserted mid-FILL restarts the fill from word 0.
- RUN: ready=1 and the FSM stays in RUN until reset. A request is accepted on any cycle where req=1 and ready=1; there is no back-pressure, and a new request is allowed every cycle on each port.
- Fetch: response appears RD_LAT cycles after the accept edge.
  - Good address: instr_valid=1 and instr_data = word.
  - Bad address: instr_valid=1, instr_data=0, addr_err=1.
- Load: same timing on data_rvalid/data_rdata; a bad address returns 0 with addr_err=1.
- Store: at the accept edge, for each i with data_be[i]=1, byte i of mem[idx] takes byte i of data_wdata; other bytes are unchanged.
  - data_be=0 means no change.
  - Bad address: no write occurs; addr_err pulses RD_LAT cycles later.
- addr_err is the OR of both ports' error slots in the same cycle.
- Same-cycle store and fetch to the same word: the fetch returns the pre-store value (read-before-write).
  - A fetch or load accepted on the cycle after the store returns the new value.
- RD_LAT=2 adds one output register stage after the array read. Array contents are sampled at the accept edge for either latency.
- Both ports operate independently and simultaneously; the only shared state is the array.

Test Plan:
- Reset and fill: DEPTH=16, INIT_VAL=32'hA5A5A5A5; pulse reset, then release.
  - ready rises exactly 16 cycles after release.
  - A data_req issued during FILL gives no data_rvalid.
  - A subsequent load of addr 0x3C returns A5A5A5A5 after RD_LAT cycles.
- Byte-enable store: in RUN, store 0x11223344 to addr 0x8 with be=4'b1111, then store 0xFFFFFFFF to 0x8 with be=4'b0101.
  - A load of 0x8 returns 0x11FF33FF.
- Latency: run back-to-back fetches of 0x0, 0x4, 0x8 on consecutive cycles with RD_LAT=1, then again with RD_LAT=2.
  - instr_valid is high for 3 consecutive cycles, starting 1 cycle (RD_LAT=1) or 2 cycles (RD_LAT=2) after the first accept.
  - Data comes out in order.
- Collision: in the same cycle, store 0xDEADBEEF to 0x10 and fetch 0x10 (word previously 0).
  - The fetch returns 0.
  - A fetch of 0x10 on the next cycle returns 0xDEADBEEF.
- Address errors: load 0x2 (misaligned) and load 0x800 (out of range for DEPTH=512).
  - Each gives data_rvalid=1 with data_rdata=0 and addr_err=1.
  - A store to 0x802 leaves every word unchanged and pulses addr_err.
- Reset mid-operation: assert reset while an RD_LAT=2 load is in flight.
  - No data_rvalid appears.
  - All outputs go to 0 immediately.
  - FILL reruns for DEPTH cycles.
